// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 2-flop synchroniser, 8N1 frame FSM and a one-entry valid/ready output register.
// Define UART_RX_PARITY_EN for 8E1 frames, which adds the PARITY state and the parity_err port.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk100,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t      state;
  logic        sync1, line;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        byte_done, fe_pend;
  logic        cnt_zero;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
`endif

  assign cnt_zero = (cnt == 16'd0);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= 1'b1;
      line      <= 1'b1;
      state     <= IDLE;
      cnt       <= 16'd0;
      idx       <= 3'd0;
      shreg     <= 8'd0;
      byte_done <= 1'b0;
      fe_pend   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
`endif
    end else begin
      sync1     <= uart_rx;
      line      <= sync1;
      byte_done <= 1'b0;
      fe_pend   <= 1'b0;
      case (state)
        IDLE:
          if (!line) begin
            state <= START;
            cnt   <= HALF;
          end
        START:
          if (!cnt_zero) cnt <= cnt - 16'd1;
          else if (!line) begin
            state <= DATA;
            cnt   <= FULL;
            idx   <= 3'd0;
          end else state <= IDLE;
        DATA:
          if (!cnt_zero) cnt <= cnt - 16'd1;
          else begin
            shreg <= {line, shreg[7:1]};
            cnt   <= FULL;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (!cnt_zero) cnt <= cnt - 16'd1;
          else begin
            par_bad <= line ^ (^shreg);
            cnt     <= FULL;
            state   <= STOP;
          end
`endif
        // Re-arming at the stop midpoint leaves half a bit to catch an immediate start bit.
        STOP:
          if (!cnt_zero) cnt <= cnt - 16'd1;
          else if (line) begin
            byte_done <= 1'b1;
            state     <= IDLE;
          end else begin
            fe_pend <= 1'b1;
            state   <= BREAK;
          end
        BREAK:
          if (line) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Single-entry output register; a completing byte may replace one handed off in the same cycle.
  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= fe_pend;
      overrun   <= 1'b0;
      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
          parity_err <= par_bad;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

Receive-side UART deframer for the FPGA debug path, between the `uart_rx` pin from the FTDI chip and the debug harness command parser. It performs these steps:
- synchronises the asynchronous serial line;
- detects and validates 8N1 frames, or 8E1 frames when parity is configured;
- presents each received byte on a valid/ready interface to the harness.

It also flags framing errors, parity errors and overruns so the harness can resynchronise its command stream.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200 baud); legal range 8–65535.
- `clk100`  input  1  system clock, 100 MHz; all logic on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `uart_rx`  input  1  raw serial line, idle high, asynchronous to `clk100`.
- `rx_data`  output  8  received byte, LSB = first data bit.
- `rx_valid`  output  1  `rx_data` holds an untaken byte.
- `rx_ready`  input  1  consumer accepts the byte when `rx_valid && rx_ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled low.
- `overrun`  output  1  one-cycle pulse: a completed byte was dropped because the output was full.
- `busy`  output  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser.** `uart_rx` passes through a 2-flop synchroniser; the reset value of both flops is 1. All references to the line below mean the synchronised value.
- **FSM states.** IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
- **IDLE.**
  - A line value of 0 enters START and loads the bit counter with `CLKS_PER_BIT/2 - 1`, using integer division.
- **START.**
  - On counter expiry, sample the line.
  - 0: enter DATA, with the counter at `CLKS_PER_BIT-1` and the bit index at 0.
  - 1: glitch; return to IDLE with no flag raised.
- **DATA.**
  - On each counter expiry, shift the sample into a shift register LSB-first and reload the counter.
  - After index 7, go to PARITY if it is compiled in, otherwise to STOP.
- **STOP.**
  - On expiry, sample the line.
  - 1: byte complete; go to IDLE.
  - 0: pulse `frame_err`, discard the byte and enter BREAK.
- **BREAK.** Stays until the line reads 1, then returns to IDLE. This prevents a break condition from being decoded as repeated 0x00 bytes.
- **Output register** (single entry). On byte completion:
  - if `rx_valid` is 0, or `rx_ready` is 1 in the same cycle: load `rx_data` and set `rx_valid`;
  - otherwise: keep the old byte, drop the new one and pulse `overrun`.
- **Handshake.**
  - `rx_valid` clears on the cycle after a handshake, unless a new byte loads in that same cycle.
  - `rx_data` is stable while `rx_valid` is high.
- **Error priority.** `frame_err` and `overrun` are never both asserted for one frame; a frame error wins and the byte is not offered.

## Timing
- **Reset values.** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, FSM=IDLE, synchroniser=1s.
- **Reset mid-frame.** Aborts immediately. No partial byte is ever presented; after release the FSM waits in IDLE for the next falling edge.
- **Input latency.** 2 cycles from a pin change to the FSM seeing it (synchroniser).
- **Sample points.** Each bit is sampled at its midpoint ±1 cycle.
- **Output latency.** `rx_valid` rises exactly 1 cycle after the stop-bit sample edge.
- **Error pulses.** `frame_err` rises 1 cycle after the stop-bit sample edge; `overrun` rises in the completion cycle.
- **Back-to-back frames.** The FSM re-arms in IDLE at the stop-bit midpoint, so a start bit following immediately is accepted. Sustained throughput is 1 byte per `10*CLKS_PER_BIT` cycles (11 with parity).
- **Accept timing.** The consumer may hold `rx_ready` high permanently; each byte is then taken in the cycle it becomes valid plus 1.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:**
  - the PARITY state is included; the frame is 8E1;
  - the parity sample must equal the XOR of the 8 data bits;
  - on mismatch the byte is still delivered, and the output port `parity_err` (1 bit, reset 0) is high for the same cycles as `rx_valid` for that byte;
  - overrun rules are unchanged.
- **Undefined:** the frame is 8N1, and there is no `parity_err` port and no PARITY state.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.

- **Single byte.** After reset, send 0xA5 with `rx_ready`=1 → one `rx_valid` cycle with `rx_data`=0xA5, then `rx_valid`=0; no error pulses.
- **Glitch rejection.** Drive a 4-cycle low pulse on an idle line → `busy` rises then returns to 0; no `rx_valid` and no `frame_err`.
- **Framing error.**
  - Send 0x3C with the stop bit held low for 40 cycles, then release the line → one `frame_err` pulse, no `rx_valid`.
  - A following 0x11 frame is received correctly.
- **Overrun.**
  - Hold `rx_ready`=0 and send 0x01 then 0x02 back-to-back → `rx_data`=0x01 valid, and one `overrun` pulse at the completion of 0x02.
  - Raising `rx_ready` then yields only 0x01.
- **Same-cycle load.** Assert `rx_ready` exactly in the completion cycle of a second byte → the old byte transfers and the new byte loads with no overrun; `rx_valid` stays high.
- **Reset and parity.**
  - Assert `reset_n` low at data bit 4 of 0xFF → all outputs return to reset values; the next 0x5A is received correctly.
  - With `UART_RX_PARITY_EN`, 0x07 sent with a wrong parity bit → `rx_data`=0x07 with `parity_err`=1.
